// File: rtl/csa_sum_display_pkg.sv
// Shared types and constants for the carry-save-adder sum display: conversion FSM states,
// BCD payload layout and active-low 7-segment glyphs ({g,f,e,d,c,b,a}).
package csa_sum_display_pkg;

    localparam int unsigned SUM_W   = 6;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned BCD_W   = 2 * NIB_W;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    typedef struct packed {
        logic [NIB_W-1:0] tens;
        logic [NIB_W-1:0] ones;
    } bcd_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [AN_W-1:0] AN_DIGIT0 = 4'b1110;
    localparam logic [AN_W-1:0] AN_DIGIT1 = 4'b1101;
    localparam logic [AN_W-1:0] AN_OFF    = 4'b1111;

    // Double-dabble correction: a nibble that would reach 10+ after doubling gets +3 first.
    function automatic logic [NIB_W-1:0] dd_adjust(input logic [NIB_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/csa_sum_display_seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern; codes 10-15 blank the digit.
module csa_sum_display_seg7_decoder
    import csa_sum_display_pkg::*;
(
    input  logic [NIB_W-1:0] bcd_in,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd_in)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/csa_sum_display.sv
// Captures the 6-bit adder sum on a strobe, converts it to two BCD digits with a sequential
// double-dabble engine and scans the result onto the Basys3 4-digit multiplexed display.
module csa_sum_display
    import csa_sum_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             busy,
    output logic [BCD_W-1:0] bcd_out,
    output logic [AN_W-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp
);

    localparam int unsigned REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SH_W  = BCD_W + SUM_W;

    conv_state_e       state_q, state_d;
    logic [SUM_W-1:0]  shreg_q, shreg_d;
    bcd_t              scratch_q, scratch_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    bcd_t              bcd_q, bcd_d;

    logic [REF_W-1:0]  refresh_q, refresh_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [AN_W-1:0]   an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    bcd_t              adj;
    logic [SH_W-1:0]   shifted;
    logic              wrap;
    logic [NIB_W-1:0]  dec_nib;
    logic [SEG_W-1:0]  dec_seg_c;

    // Conversion FSM: capture, six adjust-and-shift steps, then publish.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        busy_d    = busy_q;
        bcd_d     = bcd_q;
        adj       = '0;
        shifted   = '0;

        case (state_q)
            ST_IDLE: begin
                if (sum_valid) begin
                    shreg_d   = sum_in;
                    scratch_d = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                adj.tens  = dd_adjust(scratch_q.tens);
                adj.ones  = dd_adjust(scratch_q.ones);
                shifted   = {adj, shreg_q} << 1;
                scratch_d = shifted[SH_W-1:SUM_W];
                shreg_d   = shifted[SUM_W-1:0];
                count_d   = count_q + CNT_W'(1);
                if (count_q == CNT_W'(SUM_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Digit scan: slot advances on each refresh wrap; anodes and segments are registered.
    always_comb begin
        wrap      = (refresh_q == REF_W'(REFRESH_DIV - 1));
        refresh_d = wrap ? '0 : refresh_q + REF_W'(1);
        idx_d     = wrap ? idx_q + IDX_W'(1) : idx_q;
        dec_nib   = 4'hF;
        an_d      = AN_OFF;

        case (idx_q)
            2'd0: begin
                dec_nib = bcd_q.ones;
                an_d    = AN_DIGIT0;
            end
            2'd1: begin
                dec_nib = bcd_q.tens;
                an_d    = (bcd_q.tens == 4'd0) ? AN_OFF : AN_DIGIT1;
            end
            default: begin
                dec_nib = 4'hF;
                an_d    = AN_OFF;
            end
        endcase

        seg_d = dec_seg_c;
    end

    csa_sum_display_seg7_decoder u_dec (
        .bcd_in (dec_nib),
        .seg_c  (dec_seg_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            bcd_q     <= '0;
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy    = busy_q;
    assign bcd_out = bcd_q;
    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = 1'b1;

endmodule
